// File: rtl/adc_peak_window.sv
// adc_peak_window: windowed max/min/peak-to-peak ADC amplitude meter with settle phase and clip pulse
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   sample_en  1-clk strobe, adc_data valid this cycle
//   adc_data   unsigned ADC sample
//   restart    1-clk pulse: abort window and re-enter settle
//   peak_max   max sample of last completed window
//   peak_min   min sample of last completed window
//   peak_pp    peak_max - peak_min of last completed window
//   win_valid  1-clk pulse when peak_* update
//   clip       1-clk pulse for a clipping sample accepted while accumulating
//   settling   high while discarding settle samples
module adc_peak_window #(
  parameter int DATA_W     = 12,
  parameter int WIN_LEN    = 512,
  parameter int SETTLE_LEN = 16,
  parameter int CLIP_HI    = 4000,
  parameter int CLIP_LO    = 95
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              restart,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  output logic [DATA_W-1:0] peak_pp,
  output logic              win_valid,
  output logic              clip,
  output logic              settling
);
  localparam int SW = SETTLE_LEN > 1 ? $clog2(SETTLE_LEN) : 1;
  localparam int WW = $clog2(WIN_LEN);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_LEN > 0 ? SETTLE_LEN - 1 : 0);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
  localparam logic [DATA_W-1:0] HI = DATA_W'(CLIP_HI);
  localparam logic [DATA_W-1:0] LO = DATA_W'(CLIP_LO);

  typedef enum logic {SETTLE, ACCUM} state_t;
  localparam state_t INIT = SETTLE_LEN > 0 ? SETTLE : ACCUM;

  state_t state, state_n;
  logic [SW-1:0] settle_cnt, settle_cnt_n;
  logic [WW-1:0] win_cnt, win_cnt_n;
  logic [DATA_W-1:0] run_max, run_max_n, run_min, run_min_n;
  logic [DATA_W-1:0] peak_max_n, peak_min_n, peak_pp_n;
  logic win_valid_n, clip_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= INIT;
      settle_cnt <= '0;
      win_cnt    <= '0;
      run_max    <= '0;
      run_min    <= '0;
      peak_max   <= '0;
      peak_min   <= '0;
      peak_pp    <= '0;
      win_valid  <= 1'b0;
      clip       <= 1'b0;
    end else begin
      state      <= state_n;
      settle_cnt <= settle_cnt_n;
      win_cnt    <= win_cnt_n;
      run_max    <= run_max_n;
      run_min    <= run_min_n;
      peak_max   <= peak_max_n;
      peak_min   <= peak_min_n;
      peak_pp    <= peak_pp_n;
      win_valid  <= win_valid_n;
      clip       <= clip_n;
    end
  end

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    win_cnt_n    = win_cnt;
    run_max_n    = run_max;
    run_min_n    = run_min;
    peak_max_n   = peak_max;
    peak_min_n   = peak_min;
    peak_pp_n    = peak_pp;
    win_valid_n  = 1'b0;
    clip_n       = 1'b0;
    if (restart) begin
      state_n      = INIT;
      settle_cnt_n = '0;
      win_cnt_n    = '0;
    end else if (sample_en && state == SETTLE) begin
      state_n      = settle_cnt == SETTLE_LAST ? ACCUM : SETTLE;
      settle_cnt_n = settle_cnt == SETTLE_LAST ? '0 : settle_cnt + SW'(1);
    end else if (sample_en) begin
      // win_cnt == 0 marks the first sample, which seeds both extremes
      run_max_n = (win_cnt == '0 || adc_data > run_max) ? adc_data : run_max;
      run_min_n = (win_cnt == '0 || adc_data < run_min) ? adc_data : run_min;
      clip_n    = adc_data >= HI || adc_data <= LO;
      win_cnt_n = win_cnt == WIN_LAST ? '0 : win_cnt + WW'(1);
      if (win_cnt == WIN_LAST) begin
        peak_max_n  = run_max_n;
        peak_min_n  = run_min_n;
        peak_pp_n   = run_max_n - run_min_n;
        win_valid_n = 1'b1;
      end
    end
  end

  assign settling = state == SETTLE;
endmodule
